// File: rtl/pa_soc_prog_loader_pkg.sv
// Shared constants and state encoding for the program loader.
// PA_SOC_LOADER_CHECKSUM_EN (see pa_soc_prog_loader.sv) enables the trailing
// checksum phase; the state encoding is identical in both builds.
package pa_soc_prog_loader_pkg;

  localparam int PA_SOC_ROM_DEPTH  = 16;
  localparam int PA_SOC_ROM_ADDR_W = 4;
  localparam int PA_SOC_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WR    = 3'd3,
    ST_CK_HI = 3'd4,
    ST_CK_LO = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } loader_state_e;

  // States in which a load is in progress (drives busy_o).
  function automatic logic is_loading(loader_state_e s);
    return (s == ST_HI) || (s == ST_LO) || (s == ST_WR) ||
           (s == ST_CK_HI) || (s == ST_CK_LO);
  endfunction

  // States from which start_i is honoured.
  function automatic logic can_start(loader_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/pa_soc_nib_assembler.sv
// Nibble-to-byte assembler for the program loader.
// Handshake: a nibble transfers on a rising clock edge where nib_valid and
// nib_ready are both 1; nib_ready depends only on the phase inputs, never on
// nib_valid. The high nibble arrives first. When store is set during the low
// phase, the assembled byte is registered and byte_valid pulses for exactly
// the following cycle. byte_now is the combinational {hi, incoming nibble},
// used by the caller to check the checksum byte without storing it.
module pa_soc_nib_assembler (
  input  logic       clk,
  input  logic       rst,
  input  logic       hi_phase,
  input  logic       lo_phase,
  input  logic       store,
  input  logic       nib_valid,
  input  logic [3:0] nib_data,
  output logic       nib_ready,
  output logic       xfer,
  output logic [7:0] byte_now,
  output logic       byte_valid,
  output logic [7:0] data_byte
);

  logic [3:0] hi_q;

  assign nib_ready = hi_phase | lo_phase;
  assign xfer      = nib_ready & nib_valid;
  assign byte_now  = {hi_q, nib_data};

  // Latch the high nibble, then register the byte and its one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= 4'h0;
      data_byte  <= 8'h00;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= xfer & lo_phase & store;
      if (xfer & hi_phase) hi_q <= nib_data;
      if (xfer & lo_phase & store) data_byte <= byte_now;
    end
  end

endmodule

// File: rtl/pa_soc_prog_loader.sv
// Program ROM loader: assembles a nibble stream into bytes, writes them to
// program memory, and releases the core from reset after a clean load.
// Optional macro PA_SOC_LOADER_CHECKSUM_EN adds a trailing checksum byte that
// must equal the mod-256 sum of all program bytes; without it the load ends
// after the last byte and only a timeout can fail it.
module pa_soc_prog_loader
  import pa_soc_prog_loader_pkg::*;
#(
  parameter int DEPTH   = PA_SOC_ROM_DEPTH,
  parameter int ADDR_W  = PA_SOC_ROM_ADDR_W,
  parameter int TIMEOUT = PA_SOC_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              nib_valid_i,
  input  logic [3:0]        nib_data_i,
  output logic              nib_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              cpu_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        TMO_LAST  = 8'(TIMEOUT - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tmo_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              busy_q, done_q, err_q, cpu_rst_n_q;
  logic              hi_phase, lo_phase, xfer, tmo_hit, start_go;
  logic [7:0]        byte_now;
  logic [7:0]        data_byte;

  assign hi_phase = (state_q == ST_HI) || (state_q == ST_CK_HI);
  assign lo_phase = (state_q == ST_LO) || (state_q == ST_CK_LO);
  assign start_go = start_i && can_start(state_q);
  // The idle counter reaching TIMEOUT on this edge ends the load.
  assign tmo_hit  = nib_ready_o && !xfer && (tmo_q == TMO_LAST);

  pa_soc_nib_assembler u_asm (
    .clk        (clk_i),
    .rst        (rst_i),
    .hi_phase   (hi_phase),
    .lo_phase   (lo_phase),
    .store      (state_q == ST_LO),
    .nib_valid  (nib_valid_i),
    .nib_data   (nib_data_i),
    .nib_ready  (nib_ready_o),
    .xfer       (xfer),
    .byte_now   (byte_now),
    .byte_valid (wr_en_o),
    .data_byte  (data_byte)
  );

`ifdef PA_SOC_LOADER_CHECKSUM_EN
  logic [7:0] acc_q;

  // Running mod-256 sum of the bytes written in this load.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_go) acc_q <= 8'h00;
    else if (state_q == ST_WR) acc_q <= acc_q + data_byte;
  end
`else
  logic unused_byte_now;
  assign unused_byte_now = ^byte_now;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start_i) state_d = ST_HI;
      ST_HI: begin
        if (xfer)         state_d = ST_LO;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_LO: begin
        if (xfer)         state_d = ST_WR;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_WR: begin
`ifdef PA_SOC_LOADER_CHECKSUM_EN
        state_d = (addr_q == ADDR_LAST) ? ST_CK_HI : ST_HI;
`else
        state_d = (addr_q == ADDR_LAST) ? ST_DONE : ST_HI;
`endif
      end
`ifdef PA_SOC_LOADER_CHECKSUM_EN
      ST_CK_HI: begin
        if (xfer)         state_d = ST_CK_LO;
        else if (tmo_hit) state_d = ST_ERR;
      end
      ST_CK_LO: begin
        if (xfer)         state_d = (byte_now == acc_q) ? ST_DONE : ST_ERR;
        else if (tmo_hit) state_d = ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Address and idle counters, write address hold, registered status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      tmo_q       <= 8'h00;
      wr_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      busy_q      <= is_loading(state_d);
      done_q      <= (state_d == ST_DONE);
      err_q       <= (state_d == ST_ERR);
      // Release the core only after a full cycle in DONE.
      cpu_rst_n_q <= (state_q == ST_DONE) && (state_d == ST_DONE);
      if (start_go) begin
        addr_q <= '0;
        tmo_q  <= 8'h00;
      end else begin
        if ((state_q == ST_WR) && (addr_q != ADDR_LAST)) addr_q <= addr_q + ADDR_W'(1);
        if (nib_ready_o) tmo_q <= xfer ? 8'h00 : tmo_q + 8'd1;
      end
      if ((state_q == ST_LO) && xfer) wr_addr_q <= addr_q;
    end
  end

  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = data_byte;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cpu_rst_n_o = cpu_rst_n_q;

endmodule

// File: tb/tb_pa_soc_prog_loader.sv
// Directed bench for pa_soc_prog_loader. Honours PA_SOC_LOADER_CHECKSUM_EN
// so the same bench covers both builds.
module tb_pa_soc_prog_loader;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_i, start_i, nib_valid_i;
  logic [3:0] nib_data_i;
  logic       nib_ready_o, wr_en_o, cpu_rst_n_o, busy_o, done_o, err_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_wr  = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  logic [7:0]  img[16];
  logic [7:0]  sum;
  int          wr_base, cyc;

  pa_soc_prog_loader #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .nib_valid_i (nib_valid_i),
    .nib_data_i  (nib_data_i),
    .nib_ready_o (nib_ready_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drivers.
  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_busy", 16'(busy_o), 16'd1);
    check("start_done_clr", 16'(done_o), 16'd0);
    check("start_err_clr", 16'(err_o), 16'd0);
    check("start_cpu_rst", 16'(cpu_rst_n_o), 16'd0);
  endtask

  task automatic send_nib(input logic [3:0] d, input int gap);
    int w;
    nib_valid_i = 1'b0;
    repeat (gap) tick();
    nib_valid_i = 1'b1;
    nib_data_i  = d;
    w = 0;
    while (!nib_ready_o && w < 20) begin
      tick();
      w++;
    end
    check("nib_ready_wait", 16'(nib_ready_o), 16'd1);
    tick();
    nib_valid_i = 1'b0;
  endtask

  task automatic send_byte(input int idx, input int max_gap);
    logic [7:0] b;
    b = img[idx];
    send_nib(b[7:4], $urandom_range(0, max_gap));
    exp_q.push_back({4'(idx), b});
    send_nib(b[3:0], $urandom_range(0, max_gap));
  endtask

  task automatic wait_result(input logic exp_ok);
    int c;
    c = 0;
    while (!(done_o || err_o) && c < 20) begin
      tick();
      c++;
    end
    check("res_done", 16'(done_o), 16'(exp_ok));
    check("res_err", 16'(err_o), 16'(!exp_ok));
    check("res_busy", 16'(busy_o), 16'd0);
    check("res_cpu_rst_entry", 16'(cpu_rst_n_o), 16'd0);
    tick();
    check("res_cpu_rst_after", 16'(cpu_rst_n_o), 16'(exp_ok));
    check("res_queue_empty", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic run_load(input logic [7:0] ck, input int max_gap, input logic exp_ok);
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(i, max_gap);
`ifdef PA_SOC_LOADER_CHECKSUM_EN
    send_nib(ck[7:4], $urandom_range(0, max_gap));
    send_nib(ck[3:0], $urandom_range(0, max_gap));
`else
    if (ck == 8'h00) n_vec = n_vec + 0;
`endif
    wait_result(exp_ok);
  endtask

  initial begin
    // Scoreboard: every write strobe pops the next expected {addr, data}.
    fork
      forever begin
        @(negedge clk);
        if (wr_en_o === 1'b1) begin
          n_wr++;
          check("wr_ready_low", 16'(nib_ready_o), 16'd0);
          n_vec++;
          assert (exp_q.size() > 0) else begin
            n_err++;
            $error("FAIL wr_unexpected: observed write %h:%h expected none", wr_addr_o, wr_data_o);
          end
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("wr_addr_data", {4'h0, wr_addr_o, wr_data_o}, {4'h0, mon_e});
          end
        end
      end
    join_none

    // Reset, then idle.
    rst_i = 1'b1; start_i = 1'b0; nib_valid_i = 1'b0; nib_data_i = 4'h0;
    repeat (3) tick();
    rst_i = 1'b0;
    repeat (20) tick();
    check("rst_cpu_rst", 16'(cpu_rst_n_o), 16'd0);
    check("rst_busy", 16'(busy_o), 16'd0);
    check("rst_done", 16'(done_o), 16'd0);
    check("rst_err", 16'(err_o), 16'd0);
    check("rst_ready", 16'(nib_ready_o), 16'd0);
    check("rst_no_writes", 16'(n_wr), 16'd0);

    // Full load: byte0=0x35, byte15=0xF0, rest zero; checksum 0x25.
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[0]  = 8'h35;
    img[15] = 8'hF0;
    wr_base = n_wr;
    run_load(8'h25, 0, 1'b1);
    check("load_a_writes", 16'(n_wr - wr_base), 16'd16);

`ifdef PA_SOC_LOADER_CHECKSUM_EN
    // Bad checksum, then a clean reload.
    run_load(8'h26, 0, 1'b0);
`endif
    run_load(8'h25, 0, 1'b1);

    // Random bytes with random gaps, kept below the idle limit.
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'($urandom_range(0, 255));
      sum    = sum + img[i];
    end
    wr_base = n_wr;
    run_load(sum, TMO - 1, 1'b1);
    check("gap_writes", 16'(n_wr - wr_base), 16'd16);

    // Timeout: stop after 5 nibbles; err_o after exactly TMO idle cycles.
    wr_base = n_wr;
    pulse_start();
    send_byte(0, 0);
    send_byte(1, 0);
    send_nib(img[2][7:4], 0);
    cyc = 0;
    while (!err_o && cyc < 20) begin
      tick();
      cyc++;
    end
    check("tmo_cycles", 16'(cyc), 16'(TMO));
    check("tmo_err", 16'(err_o), 16'd1);
    check("tmo_done", 16'(done_o), 16'd0);
    check("tmo_writes", 16'(n_wr - wr_base), 16'd2);
    tick();
    check("tmo_cpu_rst", 16'(cpu_rst_n_o), 16'd0);

    // Mid-load start is ignored; reset mid-load returns to idle.
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(i, 0);
    start_i = 1'b1;
    tick();
    tick();
    start_i = 1'b0;
    check("midstart_busy", 16'(busy_o), 16'd1);
    for (int i = 3; i < 5; i++) send_byte(i, 0);
    tick();
    check("midrst_queue_empty", 16'(exp_q.size()), 16'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_busy", 16'(busy_o), 16'd0);
    check("midrst_cpu_rst", 16'(cpu_rst_n_o), 16'd0);
    check("midrst_ready", 16'(nib_ready_o), 16'd0);
    check("midrst_done", 16'(done_o), 16'd0);
    repeat (TMO + 4) tick();
    check("midrst_err_idle", 16'(err_o), 16'd0);
    check("midrst_busy_idle", 16'(busy_o), 16'd0);

    check("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
